// File: rtl/sprite_engine.sv
// sprite_engine: hit-tests up to NUM_SPRITES animated sprites and emits the winning sheet address.
// Latency 2 cycles from h_cnt/v_cnt to outputs, 1 pixel/clock.
// No backpressure: never stalls. Optional MIRROR_EN macro builds horizontal mirroring.
module sprite_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 10,
    parameter int SPR_H       = 10,
    parameter int SHEET_W     = 360,
    parameter int SHEET_SIZE  = 86400,
    parameter int ADDR_W      = 17,
    parameter int ANIM_FRAMES = 4,
    parameter int FRAME_DIV   = 8,
    parameter int SCALE_SHIFT = 1,
    localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [9:0]                    h_cnt,
    input  logic [9:0]                    v_cnt,
    input  logic                          frame_tick,
    input  logic [NUM_SPRITES-1:0]        spr_en,
    input  logic [9*NUM_SPRITES-1:0]      spr_x,
    input  logic [9*NUM_SPRITES-1:0]      spr_y,
    input  logic [ADDR_W*NUM_SPRITES-1:0] spr_base,
    input  logic [NUM_SPRITES-1:0]        spr_anim,
    input  logic [NUM_SPRITES-1:0]        spr_flip,
    output logic [ADDR_W-1:0]             pixel_addr,
    output logic                          is_object,
    output logic [SEL_W-1:0]              obj_id
);
    localparam int FI_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int DV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int RAW_W = ADDR_W + 1;

    logic [9:0] x, y;
    assign x = h_cnt >> SCALE_SHIFT;
    assign y = v_cnt >> SCALE_SHIFT;

    // Animation state
    logic [DV_W-1:0]                   div_cnt;
    logic [NUM_SPRITES-1:0][FI_W-1:0]  frame_idx;
    logic                              div_wrap;
    assign div_wrap = (div_cnt == DV_W'(FRAME_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            frame_idx <= '0;
        end else begin
            if (frame_tick)
                div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (!spr_en[i])
                    frame_idx[i] <= '0;
                else if (frame_tick && div_wrap && spr_anim[i])
                    frame_idx[i] <= (frame_idx[i] == FI_W'(ANIM_FRAMES - 1)) ? '0 : frame_idx[i] + 1'b1;
            end
        end
    end

    // Stage 1: per-slot hit test at 10 bits so the right edge never wraps
    logic [NUM_SPRITES-1:0]             hit_c, hit_q;
    logic [NUM_SPRITES-1:0][9:0]        dx_c, dy_c, dx_q, dy_q;
    logic [NUM_SPRITES-1:0][FI_W-1:0]   fr_q;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0] base_q;

    always_comb begin
        hit_c = '0;
        dx_c  = '0;
        dy_c  = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            logic [9:0] sx, sy;
            sx       = {1'b0, spr_x[9*i +: 9]};
            sy       = {1'b0, spr_y[9*i +: 9]};
            hit_c[i] = spr_en[i] && (x >= sx) && (x < sx + 10'(SPR_W)) &&
                       (y >= sy) && (y < sy + 10'(SPR_H));
            dx_c[i]  = x - sx;
            dy_c[i]  = y - sy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
            fr_q   <= '0;
            base_q <= '0;
        end else begin
            hit_q  <= hit_c;
            dx_q   <= dx_c;
            dy_q   <= dy_c;
            fr_q   <= frame_idx;
            base_q <= spr_base;
        end
    end

`ifdef MIRROR_EN
    logic [NUM_SPRITES-1:0] flip_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flip_q <= '0;
        else        flip_q <= spr_flip;
    end
`else
    logic unused_flip;
    assign unused_flip = ^spr_flip;
`endif

    // Stage 2: lowest index wins, so scan downwards and let lower slots overwrite
    logic              found;
    logic [SEL_W-1:0]  sel;
    logic [9:0]        dx_s, dy_s;
    logic [FI_W-1:0]   fr_s;
    logic [ADDR_W-1:0] base_s;
    logic [RAW_W-1:0]  raw, wrapped;

    always_comb begin
        found  = 1'b0;
        sel    = '0;
        dx_s   = '0;
        dy_s   = '0;
        fr_s   = '0;
        base_s = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                found  = 1'b1;
                sel    = SEL_W'(i);
                dx_s   = dx_q[i];
                dy_s   = dy_q[i];
                fr_s   = fr_q[i];
                base_s = base_q[i];
`ifdef MIRROR_EN
                if (flip_q[i])
                    dx_s = 10'(SPR_W - 1) - dx_q[i];
`endif
            end
        end
        raw = RAW_W'(base_s) + RAW_W'(fr_s) * RAW_W'(SPR_W) + RAW_W'(dx_s) +
              RAW_W'(dy_s) * RAW_W'(SHEET_W);
        wrapped = (raw >= RAW_W'(SHEET_SIZE)) ? raw - RAW_W'(SHEET_SIZE) : raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            is_object  <= 1'b0;
            obj_id     <= '0;
        end else begin
            pixel_addr <= found ? wrapped[ADDR_W-1:0] : '0;
            is_object  <= found;
            obj_id     <= found ? sel : '0;
        end
    end
endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine with a due-cycle scoreboard of expected outputs.
module tb_sprite_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_cnt = '0, v_cnt = '0;
    logic        frame_tick = 1'b0;
    logic [3:0]  spr_en = '0, spr_anim = '0, spr_flip = '0;
    logic [35:0] spr_x = '0, spr_y = '0;
    logic [67:0] spr_base = '0;
    logic [16:0] pixel_addr;
    logic        is_object;
    logic [1:0]  obj_id;

    sprite_engine dut (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .frame_tick(frame_tick), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
        .spr_base(spr_base), .spr_anim(spr_anim), .spr_flip(spr_flip),
        .pixel_addr(pixel_addr), .is_object(is_object), .obj_id(obj_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [16:0] addr;
        logic        obj;
        logic [1:0]  id;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk({e.tag, ".addr"}, 32'(pixel_addr), 32'(e.addr));
            chk({e.tag, ".obj"},  32'(is_object),  32'(e.obj));
            chk({e.tag, ".id"},   32'(obj_id),     32'(e.id));
        end
    endtask

    task automatic pix(input int h, input int v, input int ea, input bit eo, input int ei,
                       input string tag);
        exp_t e;
        h_cnt  = 10'(h);
        v_cnt  = 10'(v);
        e.due  = cyc + 2;
        e.addr = 17'(ea);
        e.obj  = eo;
        e.id   = 2'(ei);
        e.tag  = tag;
        q.push_back(e);
        tick();
    endtask

    task automatic set_slot(input int i, input bit en, input int sx, input int sy,
                            input int base, input bit anim, input bit flip);
        spr_en[i]           = en;
        spr_x[9*i +: 9]     = 9'(sx);
        spr_y[9*i +: 9]     = 9'(sy);
        spr_base[17*i +: 17] = 17'(base);
        spr_anim[i]         = anim;
        spr_flip[i]         = flip;
    endtask

    task automatic ftick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) tick();
        chk("drain.queue_empty", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mirror_exp;
        tick();
        tick();
        chk("rst.addr", 32'(pixel_addr), 32'd0);
        chk("rst.obj",  32'(is_object),  32'd0);
        chk("rst.id",   32'(obj_id),     32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Single hit and miss just past the right edge
        set_slot(0, 1, 100, 50, 0, 0, 0);
        pix(204, 104, 722, 1, 0, "single_hit");
        pix(220, 104, 0, 0, 0, "single_miss_x110");
        pix(198, 104, 0, 0, 0, "single_miss_x99");
        pix(204, 120, 0, 0, 0, "single_miss_y60");

        // Priority between overlapping slots
        set_slot(0, 0, 100, 50, 0, 0, 0);
        set_slot(1, 1, 20, 20, 1000, 0, 0);
        set_slot(2, 1, 20, 20, 2000, 0, 0);
        pix(50, 46, 2085, 1, 1, "prio_slot1");
        set_slot(1, 0, 20, 20, 1000, 0, 0);
        pix(50, 46, 3085, 1, 2, "prio_slot2");
        set_slot(2, 0, 20, 20, 2000, 0, 0);
        pix(50, 46, 0, 0, 0, "prio_none");

        // Address wrap and right screen edge
        set_slot(0, 1, 100, 50, 86395, 0, 0);
        pix(218, 100, 4, 1, 0, "wrap_dx9");
        set_slot(0, 1, 505, 50, 0, 0, 0);
        pix(1018, 100, 4, 1, 0, "edge_x509");
        pix(0, 100, 0, 0, 0, "edge_x0");
        pix(1008, 100, 0, 0, 0, "edge_x504");

        // Mirroring
`ifdef MIRROR_EN
        mirror_exp = 7;
`else
        mirror_exp = 2;
`endif
        set_slot(0, 1, 100, 50, 0, 0, 1);
        pix(204, 100, mirror_exp, 1, 0, "mirror_dx2");
        set_slot(0, 1, 100, 50, 0, 0, 0);
        pix(204, 100, 2, 1, 0, "noflip_dx2");
        drain();

        // Animation timing
        set_slot(0, 1, 100, 50, 0, 1, 0);
        ftick(7);
        pix(204, 100, 2, 1, 0, "anim_7ticks");
        ftick(1);
        pix(204, 100, 12, 1, 0, "anim_8ticks");
        ftick(24);
        pix(204, 100, 2, 1, 0, "anim_32ticks");
        ftick(8);
        pix(204, 100, 12, 1, 0, "anim_frame1");
        set_slot(0, 1, 100, 50, 0, 0, 0);
        ftick(16);
        pix(204, 100, 12, 1, 0, "anim_hold16");
        drain();

        // Asynchronous reset with a hit in flight
        tick();
        chk("pre_rst.obj", 32'(is_object), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.addr", 32'(pixel_addr), 32'd0);
        chk("async_rst.obj",  32'(is_object),  32'd0);
        chk("async_rst.id",   32'(obj_id),     32'd0);
        #1 rst_n = 1'b1;
        pix(204, 100, 2, 1, 0, "post_rst_frame0");

        // Disabled slot forced back to frame 0
        set_slot(0, 1, 100, 50, 0, 1, 0);
        ftick(8);
        pix(204, 100, 12, 1, 0, "reanim_frame1");
        set_slot(0, 0, 100, 50, 0, 1, 0);
        tick();
        set_slot(0, 1, 100, 50, 0, 0, 0);
        pix(204, 100, 2, 1, 0, "disable_clears_frame");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
